// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready command into SETUP/ACCESS phases on the timer's
// APB port and returns a one-cycle response with read data, slave error and timeout status.
module apb_initiator #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires while the counter holds TIMEOUT-1, i.e. during the TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed commands against a scripted APB slave, with a
// transfer-level model compared every cycle plus hand-computed expectations per scenario.
module tb_apb_initiator;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              pclk, preset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready, pslverr;
  logic [DATA_W-1:0] prdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave script: wait cycles before pready, stuck-low mode, error flag, read data.
  int          slv_wait = 0;
  bit          slv_stuck = 0;
  bit          slv_err = 0;
  logic [7:0]  slv_rdata = 8'h00;
  int          acc_n = 0;

  // Observed activity, accumulated by the compare process.
  int          psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0;
  logic [7:0]  obs_addr[$];

  // Transfer-level model state.
  bit          m_busy;
  int          m_beat;
  logic [7:0]  m_paddr, m_pwdata, m_rdata;
  logic        m_pwrite, m_rsp_valid, m_err, m_to;

  apb_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer is busy from acceptance; beat 0 is the setup cycle, beat n>=1 is
  // the n-th access cycle. It ends on a ready access cycle or on access cycle TIMEOUT.
  task automatic m_reset();
    m_busy = 1'b0; m_beat = 0;
    m_paddr = 8'h00; m_pwdata = 8'h00; m_pwrite = 1'b0;
    m_rsp_valid = 1'b0; m_rdata = 8'h00; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic m_step();
    m_rsp_valid = 1'b0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_busy   = 1'b1;
        m_beat   = 0;
        m_paddr  = cmd_addr;
        m_pwrite = cmd_write;
        m_pwdata = cmd_write ? cmd_wdata : 8'h00;
      end
    end else if (m_beat == 0) begin
      m_beat = 1;
    end else if (pready) begin
      m_busy = 1'b0; m_rsp_valid = 1'b1;
      m_rdata = m_pwrite ? 8'h00 : prdata;
      m_err = pslverr; m_to = 1'b0;
    end else if (TIMEOUT != 0 && m_beat == TIMEOUT) begin
      m_busy = 1'b0; m_rsp_valid = 1'b1;
      m_rdata = 8'h00; m_err = 1'b1; m_to = 1'b1;
    end else begin
      m_beat++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge pclk or posedge preset);
      if (preset) m_reset();
      else m_step();
    end
  end

  // Slave: pready rises after slv_wait low access cycles unless stuck.
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    forever begin
      @(posedge pclk);
      #1;
      if (psel === 1'b1 && penable === 1'b1) acc_n++;
      else acc_n = 0;
      pready  = !slv_stuck && (acc_n > slv_wait);
      pslverr = pready && slv_err;
      prdata  = slv_rdata;
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge pclk);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && (m_beat >= 1));
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("pwrite", pwrite, m_pwrite);
      chk("paddr", paddr, m_paddr);
      chk("pwdata", pwdata, m_pwdata);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_timeout", rsp_timeout, m_to);
      if (psel === 1'b1) psel_cnt++;
      if (penable === 1'b1) pen_cnt++;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        obs_addr.push_back(paddr);
        $display("txn %0d: %s addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0b timeout=%0b",
                 rsp_cnt, pwrite ? "WR" : "RD", paddr, pwdata, rsp_rdata, rsp_err, rsp_timeout);
      end
    end
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input bit hold);
    bit rdy;
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 64 && !done; n++) begin
      rdy = cmd_ready;
      @(posedge pclk);
      #1;
      if (rdy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: got no acceptance, expected accept within 64 cycles (addr 0x%02h)", a);
    end
    if (!hold) begin
      cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 8'hFF; cmd_wdata = 8'hFF;
    end
  endtask

  task automatic wait_rsp(input int maxc, output int at);
    bit got;
    got = 1'b0;
    at = -1;
    for (int n = 0; n < maxc && !got; n++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        at = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_rsp: got no rsp_valid, expected one within %0d cycles", maxc);
    end
  endtask

  task automatic settle();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int r, a, t0, t1, p0, e0, v0;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    repeat (3) @(negedge pclk);
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_paddr", paddr, 8'h00);
    preset = 1'b0;
    settle();

    // 1: zero-wait write
    slv_wait = 0; slv_err = 0;
    p0 = psel_cnt; e0 = pen_cnt; v0 = rsp_cnt;
    send(1'b1, 8'h04, 8'h5A, 1'b0);
    wait_rsp(10, r);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_paddr", paddr, 8'h04);
    chk("t1_pwdata", pwdata, 8'h5A);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_rdata", rsp_rdata, 8'h00);
    chk("t1_psel_low_at_rsp", psel, 0);
    settle();
    chk("t1_psel_cycles", psel_cnt - p0, 2);
    chk("t1_penable_cycles", pen_cnt - e0, 1);
    chk("t1_rsp_count", rsp_cnt - v0, 1);

    // 2: read with three wait cycles
    slv_wait = 3; slv_rdata = 8'hC3;
    p0 = psel_cnt; e0 = pen_cnt;
    send(1'b0, 8'h08, 8'hAA, 1'b0);
    wait_rsp(20, r);
    chk("t2_rsp_rdata", rsp_rdata, 8'hC3);
    chk("t2_rsp_err", rsp_err, 0);
    chk("t2_paddr", paddr, 8'h08);
    chk("t2_pwdata_read", pwdata, 8'h00);
    settle();
    chk("t2_penable_cycles", pen_cnt - e0, 4);
    chk("t2_psel_cycles", psel_cnt - p0, 5);

    // 3: slave error, then a command accepted in the response cycle
    slv_wait = 1; slv_err = 1; slv_rdata = 8'h5E;
    send(1'b1, 8'h0C, 8'h77, 1'b0);
    wait_rsp(20, r);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_timeout", rsp_timeout, 0);
    chk("t3_cmd_ready_in_rsp", cmd_ready, 1);
    slv_err = 0;
    send(1'b0, 8'h10, 8'h55, 1'b0);
    a = cyc;
    chk("t3_same_cycle_accept", a, r + 1);
    chk("t3_psel_setup", psel, 1);
    chk("t3_penable_setup", penable, 0);
    wait_rsp(20, r);
    chk("t3_read_rdata", rsp_rdata, 8'h5E);
    chk("t3_read_err", rsp_err, 0);
    settle();

    // 4: timeout, then a normal read
    slv_stuck = 1; slv_rdata = 8'hEE;
    p0 = psel_cnt; e0 = pen_cnt;
    send(1'b0, 8'h14, 8'h00, 1'b0);
    wait_rsp(40, r);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_timeout", rsp_timeout, 1);
    chk("t4_rsp_rdata", rsp_rdata, 8'h00);
    chk("t4_psel_dropped", psel, 0);
    chk("t4_penable_dropped", penable, 0);
    settle();
    chk("t4_access_cycles", pen_cnt - e0, 16);
    chk("t4_psel_cycles", psel_cnt - p0, 17);
    slv_stuck = 0; slv_wait = 2; slv_rdata = 8'h3C;
    send(1'b0, 8'h20, 8'h00, 1'b0);
    wait_rsp(20, r);
    chk("t4_followup_rdata", rsp_rdata, 8'h3C);
    chk("t4_followup_err", rsp_err, 0);
    chk("t4_followup_timeout", rsp_timeout, 0);
    settle();

    // 5: four back-to-back writes, zero-wait slave
    slv_wait = 0;
    p0 = psel_cnt; v0 = rsp_cnt;
    obs_addr.delete();
    send(1'b1, 8'h00, 8'hA0, 1'b1);
    t0 = cyc;
    send(1'b1, 8'h01, 8'hA1, 1'b1);
    send(1'b1, 8'h02, 8'hA2, 1'b1);
    send(1'b1, 8'h03, 8'hA3, 1'b0);
    wait_rsp(10, t1);
    chk("t5_span", t1 - t0, 11);
    settle();
    chk("t5_rsp_count", rsp_cnt - v0, 4);
    chk("t5_psel_cycles", psel_cnt - p0, 8);
    chk("t5_addr_count", obs_addr.size(), 4);
    for (int i = 0; i < obs_addr.size() && i < 4; i++)
      chk($sformatf("t5_addr_order_%0d", i), obs_addr[i], i);

    // 6: reset during ACCESS of a read
    slv_wait = 5; slv_rdata = 8'h81;
    v0 = rsp_cnt;
    send(1'b0, 8'h24, 8'h00, 1'b0);
    settle();
    chk("t6_in_access", penable, 1);
    #2;
    preset = 1'b1;
    #1;
    chk("t6_async_psel", psel, 0);
    chk("t6_async_penable", penable, 0);
    chk("t6_async_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    chk("t6_cmd_ready_after", cmd_ready, 1);
    settle();
    slv_wait = 1;
    send(1'b1, 8'h30, 8'h99, 1'b0);
    wait_rsp(20, r);
    chk("t6_new_err", rsp_err, 0);
    chk("t6_new_paddr", paddr, 8'h30);
    settle();
    chk("t6_rsp_count", rsp_cnt - v0, 1);

    repeat (2) settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
